multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Main control FSM for the multicycle RV32I core. Sequences each instruction through fetch, decode, execute, memory and writeback, and drives the datapath enables and mux selects. It generates the `ALUOp` code that the ALU decoder consumes: 00 add, 01 sub, 10 R-type, 11 I-type arithmetic. It also handles a ready-based memory handshake and flags unsupported opcodes.

## Interface
- No parameters.
- `clk`  in  1  core clock, rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `op`  in  7  opcode from the instruction register; stable from DECODE through the end of the instruction.
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `pc_write`  out  1  PC register enable.
- `adr_src`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `mem_write`  out  1  memory write strobe; held until `mem_ready`.
- `ir_write`  out  1  instruction register and OldPC enable.
- `reg_write`  out  1  register file write enable.
- `result_src`  out  2  result select: 00 ALUOut, 01 Data, 10 ALU result.
- `alu_src_a`  out  2  SrcA select: 00 PC, 01 OldPC, 10 rs1 data.
- `alu_src_b`  out  2  SrcB select: 00 rs2 data, 01 ImmExt, 10 constant 4.
- `alu_op`  out  2  to the ALU decoder.
- `imm_src`  out  2  immediate format: 00 I, 01 S, 10 B, 11 J.
- `retire`  out  1  one-cycle pulse in the final cycle of a legal instruction.
- `illegal_instr`  out  1  one-cycle pulse when DECODE sees an unsupported opcode.

## Operation
- Supported opcodes:
  - lw 0000011
  - sw 0100011
  - R-type 0110011
  - I-type ALU 0010011
  - beq 1100011
  - jal 1101111
- `imm_src` is combinational from `op`:
  - sw → 01
  - beq → 10
  - jal → 11
  - everything else → 00
- States and transitions:
  - FETCH → DECODE when `mem_ready`; otherwise stay in FETCH.
  - DECODE → MEMADR (lw/sw), EXECUTER (R), EXECUTEI (I), BEQ, JAL; any other opcode → FETCH.
  - MEMADR → MEMREAD (lw) or MEMWRITE (sw).
  - MEMREAD → MEMWB when `mem_ready`; otherwise stay.
  - MEMWRITE → FETCH when `mem_ready`; otherwise stay.
  - EXECUTER → ALUWB; EXECUTEI → ALUWB; JAL → ALUWB.
  - MEMWB → FETCH; ALUWB → FETCH; BEQ → FETCH.
- Per-state outputs. Any output not listed is 0.
  - FETCH: adr_src=0, a=00, b=10, alu_op=00, result_src=10, ir_write=mem_ready, pc_write=mem_ready.
  - DECODE: a=01, b=01, alu_op=00 (branch target computed into ALUOut).
  - MEMADR: a=10, b=01, alu_op=00.
  - MEMREAD: adr_src=1, result_src=00.
  - MEMWRITE: adr_src=1, result_src=00, mem_write=1.
  - MEMWB: result_src=01, reg_write=1.
  - EXECUTER: a=10, b=00, alu_op=10.
  - EXECUTEI: a=10, b=01, alu_op=11.
  - ALUWB: result_src=00, reg_write=1.
  - BEQ: a=10, b=00, alu_op=01, result_src=00, pc_write=zero.
  - JAL: a=01, b=10, alu_op=00, result_src=00, pc_write=1.
- `retire` is 1 in these cycles only:
  - MEMWB
  - ALUWB
  - BEQ
  - MEMWRITE when `mem_ready`=1
- `illegal_instr` is 1 in DECODE when the opcode is unsupported. No register or memory write occurs for that instruction.

## Timing
- All state updates occur on the rising edge of `clk`. Outputs are decoded from the current state. The Mealy terms are `mem_ready` in FETCH, MEMWRITE and `retire`, and `zero` in BEQ.
- `rst_n`=0 at an edge puts the FSM in FETCH, whatever the current state and inputs, including mid-instruction and mid-`mem_write`.
- Outputs after reset are the FETCH values. While `rst_n` is low at the edge, `pc_write`, `ir_write`, `reg_write` and `mem_write` follow the FETCH decode only, so no write strobe other than FETCH's is asserted.
- Latency with `mem_ready` held at 1:
  - beq: 3 cycles
  - R-type, I-type, sw, jal: 4 cycles
  - lw: 5 cycles
  - illegal opcode: 2 cycles
- Each cycle with `mem_ready`=0 in FETCH, MEMREAD or MEMWRITE adds one cycle. Outputs hold constant through the stall.
- `mem_write` stays high every stall cycle of MEMWRITE and drops in the cycle after `mem_ready` is seen.
- `mem_ready` outside FETCH, MEMREAD and MEMWRITE is ignored.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with random inputs → FETCH outputs: b=10, result_src=10, alu_op=00, `reg_write`=0, `mem_write`=0.
- R-type with `mem_ready`=1, op=0110011 → states FETCH, DECODE, EXECUTER, ALUWB. `alu_op`=10 in EXECUTER. `reg_write`=1 and `retire`=1 in cycle 4 only.
- lw with `mem_ready` low for 2 cycles in MEMREAD → 7-cycle instruction. `adr_src`=1 for 3 cycles. `result_src`=01 and `reg_write`=1 in MEMWB.
- beq: `zero`=1 → `pc_write`=1 and `alu_op`=01 in cycle 3. Repeat with `zero`=0 → `pc_write`=0. Both cases return to FETCH.
- sw with `mem_ready`=0 for 3 cycles, then jal → `mem_write` high for exactly 4 cycles. jal gives `pc_write`=1 in JAL and `reg_write`=1 in ALUWB, with `imm_src`=11.
- Illegal op=1110011 → `illegal_instr` pulses in DECODE and the FSM returns to FETCH with no writes. Then assert `rst_n`=0 during EXECUTEI → FETCH on the next edge and no ALUWB write.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Main sequencing FSM for the multicycle RV32I core: walks each instruction through
// fetch/decode/execute/memory/writeback and drives datapath enables and mux selects.
//
// state    | meaning
// FETCH    | read instruction at PC, PC+4 into PC when memory is ready
// DECODE   | register read, branch target computed into ALUOut
// MEMADR   | load/store address = rs1 + imm
// MEMREAD  | load data access, waits for mem_ready
// MEMWRITE | store access, mem_write held until mem_ready
// MEMWB    | load data written to register file
// EXECUTER | register-register ALU operation
// EXECUTEI | register-immediate ALU operation
// ALUWB    | ALUOut written to register file
// BEQ      | compare, PC <= branch target when zero
// JAL      | PC <= target, link address PC+4 computed
module multicycle_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] imm_src,
  output logic       retire,
  output logic       illegal_instr
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWRITE, MEMWB,
    EXECUTER, EXECUTEI, ALUWB, BEQ, JAL
  } state_t;

  typedef struct packed {
    logic       adr_src;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] alu_op;
    logic       fetch;
    logic       decode;
    logic       memwrite;
    logic       beq;
    logic       jal;
    logic       done;
  } moore_t;

  state_t state, nxt;
  moore_t mo;
  logic   legal;

  // Registered Moore outputs are precomputed from the state being entered.
  function automatic moore_t moore(input state_t s);
    moore_t m;
    m = '0;
    case (s)
      FETCH:    begin m.src_b = 2'b10; m.result_src = 2'b10; m.fetch = 1'b1; end
      DECODE:   begin m.src_a = 2'b01; m.src_b = 2'b01; m.decode = 1'b1; end
      MEMADR:   begin m.src_a = 2'b10; m.src_b = 2'b01; end
      MEMREAD:  m.adr_src = 1'b1;
      MEMWRITE: begin m.adr_src = 1'b1; m.mem_write = 1'b1; m.memwrite = 1'b1; end
      MEMWB:    begin m.result_src = 2'b01; m.reg_write = 1'b1; m.done = 1'b1; end
      EXECUTER: begin m.src_a = 2'b10; m.alu_op = 2'b10; end
      EXECUTEI: begin m.src_a = 2'b10; m.src_b = 2'b01; m.alu_op = 2'b11; end
      ALUWB:    begin m.reg_write = 1'b1; m.done = 1'b1; end
      BEQ:      begin m.src_a = 2'b10; m.alu_op = 2'b01; m.beq = 1'b1; m.done = 1'b1; end
      JAL:      begin m.src_a = 2'b01; m.src_b = 2'b10; m.jal = 1'b1; end
      default:  m = '0;
    endcase
    return m;
  endfunction

  always_comb begin
    legal = (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
            (op == OP_I)  || (op == OP_BEQ) || (op == OP_JAL);
  end

  always_comb begin
    nxt = state;
    case (state)
      FETCH:    if (mem_ready) nxt = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: nxt = MEMADR;
          OP_R:         nxt = EXECUTER;
          OP_I:         nxt = EXECUTEI;
          OP_BEQ:       nxt = BEQ;
          OP_JAL:       nxt = JAL;
          default:      nxt = FETCH;
        endcase
      end
      MEMADR:   nxt = (op == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  if (mem_ready) nxt = MEMWB;
      MEMWRITE: if (mem_ready) nxt = FETCH;
      EXECUTER, EXECUTEI, JAL: nxt = ALUWB;
      MEMWB, ALUWB, BEQ:       nxt = FETCH;
      default:  nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= FETCH;
      mo    <= moore(FETCH);
    end else begin
      state <= nxt;
      mo    <= moore(nxt);
    end
  end

  always_comb begin
    case (op)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  // While reset is held the strobes behave as FETCH, so an interrupted
  // instruction can never commit a register or memory write.
  assign pc_write      = rst_n ? ((mo.fetch & mem_ready) | (mo.beq & zero) | mo.jal) : mem_ready;
  assign ir_write      = rst_n ? (mo.fetch & mem_ready) : mem_ready;
  assign reg_write     = rst_n & mo.reg_write;
  assign mem_write     = rst_n & mo.mem_write;
  assign adr_src       = mo.adr_src;
  assign result_src    = mo.result_src;
  assign alu_src_a     = mo.src_a;
  assign alu_src_b     = mo.src_b;
  assign alu_op        = mo.alu_op;
  assign retire        = mo.done | (mo.memwrite & mem_ready);
  assign illegal_instr = mo.decode & ~legal;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-cycle vector table with expected state, plus
// latency sequences per opcode.
module tb_multicycle_ctrl;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BAD = 7'b1110011;

  typedef enum int {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWRITE, S_MEMWB,
    S_EXR, S_EXI, S_ALUWB, S_BEQ, S_JAL
  } bst_t;

  typedef struct {
    bit         rst;
    logic [6:0] op;
    bit         zero;
    bit         mr;
    bst_t       st;
    bit         chk;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic       zero, mem_ready;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_src;
  logic       retire, illegal_instr;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t        vecs[$];
  logic [16:0] sb[$];

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
    .ir_write(ir_write), .reg_write(reg_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .imm_src(imm_src), .retire(retire), .illegal_instr(illegal_instr)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] actual();
    return {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
            alu_src_a, alu_src_b, alu_op, imm_src, retire, illegal_instr};
  endfunction

  // Expected outputs from the state table; packing matches actual().
  function automatic logic [16:0] expect_out(bst_t st, logic [6:0] o, bit z, bit mr, bit rst);
    logic pc, adr, mw, ir, rw, ret, ill;
    logic [1:0] rs, a, b, aop, imm;
    bit legal;
    {pc, adr, mw, ir, rw, ret, ill} = '0;
    {rs, a, b, aop} = '0;
    legal = (o == OP_LW) || (o == OP_SW) || (o == OP_R) || (o == OP_I) ||
            (o == OP_BEQ) || (o == OP_JAL);
    imm = (o == OP_SW) ? 2'b01 : (o == OP_BEQ) ? 2'b10 : (o == OP_JAL) ? 2'b11 : 2'b00;
    case (st)
      S_FETCH:    begin b = 2'b10; rs = 2'b10; ir = mr; pc = mr; end
      S_DECODE:   begin a = 2'b01; b = 2'b01; ill = !legal; end
      S_MEMADR:   begin a = 2'b10; b = 2'b01; end
      S_MEMREAD:  adr = 1'b1;
      S_MEMWRITE: begin adr = 1'b1; mw = 1'b1; ret = mr; end
      S_MEMWB:    begin rs = 2'b01; rw = 1'b1; ret = 1'b1; end
      S_EXR:      begin a = 2'b10; aop = 2'b10; end
      S_EXI:      begin a = 2'b10; b = 2'b01; aop = 2'b11; end
      S_ALUWB:    begin rw = 1'b1; ret = 1'b1; end
      S_BEQ:      begin a = 2'b10; aop = 2'b01; pc = z; ret = 1'b1; end
      S_JAL:      begin a = 2'b01; b = 2'b10; pc = 1'b1; end
      default:    ;
    endcase
    if (!rst) begin
      pc = mr; ir = mr; rw = 1'b0; mw = 1'b0;
    end
    return {pc, adr, mw, ir, rw, rs, a, b, aop, imm, ret, ill};
  endfunction

  task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic add(input bit r, input logic [6:0] o, input bit z, input bit mr, input bst_t s);
    vec_t v;
    v.rst = r; v.op = o; v.zero = z; v.mr = mr; v.st = s; v.chk = 1'b1;
    vecs.push_back(v);
  endtask

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic drive(input bit r, input logic [6:0] o, input bit z, input bit mr);
    rst_n = r; op = o; zero = z; mem_ready = mr;
  endtask

  initial begin
    int lat;
    logic [6:0] lat_op[6];
    int         lat_exp[6];

    // reset with random inputs; first cycle has no defined prior state
    add(0, 7'($urandom), rb(), rb(), S_FETCH);
    vecs[0].chk = 1'b0;
    add(0, 7'($urandom), rb(), rb(), S_FETCH);
    // R-type; mem_ready low in DECODE is ignored
    add(1, OP_R, rb(), 1, S_FETCH);  add(1, OP_R, rb(), 0, S_DECODE);
    add(1, OP_R, rb(), 1, S_EXR);    add(1, OP_R, rb(), 1, S_ALUWB);
    // lw with two stall cycles in MEMREAD
    add(1, OP_LW, rb(), 1, S_FETCH); add(1, OP_LW, rb(), 1, S_DECODE);
    add(1, OP_LW, rb(), 1, S_MEMADR);
    add(1, OP_LW, rb(), 0, S_MEMREAD); add(1, OP_LW, rb(), 0, S_MEMREAD);
    add(1, OP_LW, rb(), 1, S_MEMREAD); add(1, OP_LW, rb(), 1, S_MEMWB);
    // beq taken and not taken
    add(1, OP_BEQ, rb(), 1, S_FETCH); add(1, OP_BEQ, rb(), 1, S_DECODE);
    add(1, OP_BEQ, 1, 1, S_BEQ);
    add(1, OP_BEQ, rb(), 1, S_FETCH); add(1, OP_BEQ, rb(), 1, S_DECODE);
    add(1, OP_BEQ, 0, 1, S_BEQ);
    // sw with three stall cycles, then jal
    add(1, OP_SW, rb(), 1, S_FETCH); add(1, OP_SW, rb(), 1, S_DECODE);
    add(1, OP_SW, rb(), 1, S_MEMADR);
    for (int i = 0; i < 3; i++) add(1, OP_SW, rb(), 0, S_MEMWRITE);
    add(1, OP_SW, rb(), 1, S_MEMWRITE);
    add(1, OP_JAL, rb(), 1, S_FETCH); add(1, OP_JAL, rb(), 1, S_DECODE);
    add(1, OP_JAL, rb(), 1, S_JAL);   add(1, OP_JAL, rb(), 1, S_ALUWB);
    // illegal opcode
    add(1, OP_BAD, rb(), 1, S_FETCH); add(1, OP_BAD, rb(), 1, S_DECODE);
    // I-type with fetch stall, reset during EXECUTEI
    add(1, OP_I, rb(), 0, S_FETCH); add(1, OP_I, rb(), 0, S_FETCH);
    add(1, OP_I, rb(), 1, S_FETCH); add(1, OP_I, rb(), 1, S_DECODE);
    add(0, OP_I, rb(), 1, S_EXI);
    add(1, OP_I, rb(), 0, S_FETCH);
    add(1, OP_I, rb(), 1, S_FETCH); add(1, OP_I, rb(), 1, S_DECODE);
    add(1, OP_I, rb(), 1, S_EXI);   add(1, OP_I, rb(), 1, S_ALUWB);
    // reset in the middle of a stalled store
    add(1, OP_SW, rb(), 1, S_FETCH); add(1, OP_SW, rb(), 1, S_DECODE);
    add(1, OP_SW, rb(), 1, S_MEMADR);
    add(1, OP_SW, rb(), 0, S_MEMWRITE); add(0, OP_SW, rb(), 0, S_MEMWRITE);
    add(1, OP_R, rb(), 1, S_FETCH); add(1, OP_R, rb(), 1, S_DECODE);
    add(1, OP_R, rb(), 1, S_EXR);   add(1, OP_R, rb(), 1, S_ALUWB);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].op, vecs[i].zero, vecs[i].mr);
      if (vecs[i].chk)
        sb.push_back(expect_out(vecs[i].st, vecs[i].op, vecs[i].zero, vecs[i].mr, vecs[i].rst));
      #2;
      if (vecs[i].chk && sb.size() > 0)
        check($sformatf("vec[%0d]", i), actual(), sb.pop_front());
      @(negedge clk);
    end

    // latency with mem_ready held high, FETCH cycle counted as 1
    lat_op  = '{OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL};
    lat_exp = '{5, 4, 4, 4, 3, 4};
    for (int k = 0; k < 6; k++) begin
      lat = 0;
      for (int n = 1; n <= 8 && lat == 0; n++) begin
        drive(1, lat_op[k], rb(), 1);
        #2;
        if (retire) lat = n;
        @(negedge clk);
      end
      check($sformatf("latency op=%b", lat_op[k]), 17'(lat), 17'(lat_exp[k]));
    end

    // illegal opcode: pulse on cycle 2, back in FETCH on cycle 3
    lat = 0;
    for (int n = 1; n <= 6 && lat == 0; n++) begin
      drive(1, OP_BAD, rb(), 1);
      #2;
      if (illegal_instr) lat = n;
      if (reg_write || mem_write) lat = 99;
      @(negedge clk);
    end
    check("illegal latency", 17'(lat), 17'd2);
    drive(1, OP_R, 0, 1);
    #2;
    check("fetch after illegal", 17'({ir_write, pc_write, illegal_instr}), 17'b110);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
